alu_reservation_station: RTL

ALU_RESERVATION_STATION -- requirements
Module: alu_reservation_station

---
 rtl/alu_reservation_station.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_reservation_station.sv
// Reservation station for ALU/branch ops: holds issued ops until both operands
// are ready, then dispatches the oldest ready one and registers its result.
// op_id encoding: 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5 BEQ, 6 BNE, 7 BLT, 8 BGE, 9 BLTU,
// 10 BGEU, 11 ADD, 12 SUB, 13 AND, 14 OR, 15 XOR, 16 SLT, 17 SLTU, 18 SLL, 19 SRL,
// 20 SRA, 21 ADDI, 22 ANDI, 23 ORI, 24 XORI, 25 SLTI, 26 SLTIU, 27 SLLI, 28 SRLI, 29 SRAI.
module alu_reservation_station #(
    parameter int ROB_WIDTH = 4,
    parameter int RS_DEPTH  = 16,
    parameter int CDB_PORTS = 2
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           rdy_in,
    input  logic                           clr_in,
    input  logic                           issue_valid,
    input  logic [ROB_WIDTH-1:0]           issue_rob_index,
    input  logic [5:0]                     issue_op_id,
    input  logic [31:0]                    issue_val1,
    input  logic [31:0]                    issue_val2,
    input  logic [ROB_WIDTH-1:0]           issue_dep1,
    input  logic [ROB_WIDTH-1:0]           issue_dep2,
    input  logic [31:0]                    issue_pc,
    input  logic [31:0]                    issue_offset,
    input  logic [CDB_PORTS-1:0]           cdb_valid,
    input  logic [CDB_PORTS*ROB_WIDTH-1:0] cdb_rob_index,
    input  logic [CDB_PORTS*32-1:0]        cdb_val,
    output logic                           rs_full,
    output logic [$clog2(RS_DEPTH+1)-1:0]  rs_free_cnt,
    output logic                           rs_ready,
    output logic [ROB_WIDTH-1:0]           rs_rob_index,
    output logic [31:0]                    rs_val,
    output logic                           rs_actual_br,
    output logic [31:0]                    rs_pc_jump
);
    localparam int CNT_W = $clog2(RS_DEPTH + 1);
    localparam int IDX_W = $clog2(RS_DEPTH);

    localparam logic [5:0] OP_LUI  = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL  = 6'd3,  OP_JALR  = 6'd4;
    localparam logic [5:0] OP_BEQ  = 6'd5,  OP_BNE   = 6'd6,  OP_BLT  = 6'd7,  OP_BGE   = 6'd8;
    localparam logic [5:0] OP_BLTU = 6'd9,  OP_BGEU  = 6'd10, OP_ADD  = 6'd11, OP_SUB   = 6'd12;
    localparam logic [5:0] OP_AND  = 6'd13, OP_OR    = 6'd14, OP_XOR  = 6'd15, OP_SLT   = 6'd16;
    localparam logic [5:0] OP_SLTU = 6'd17, OP_SLL   = 6'd18, OP_SRL  = 6'd19, OP_SRA   = 6'd20;
    localparam logic [5:0] OP_ADDI = 6'd21, OP_ANDI  = 6'd22, OP_ORI  = 6'd23, OP_XORI  = 6'd24;
    localparam logic [5:0] OP_SLTI = 6'd25, OP_SLTIU = 6'd26, OP_SLLI = 6'd27, OP_SRLI  = 6'd28;
    localparam logic [5:0] OP_SRAI = 6'd29;

    logic [RS_DEPTH-1:0]  busy, busy_next, elig, pick;
    // older[i][j] set means entry i was issued before entry j
    logic [RS_DEPTH-1:0]  older      [RS_DEPTH];
    logic [RS_DEPTH-1:0]  older_next [RS_DEPTH];
    logic [ROB_WIDTH-1:0] e_tag [RS_DEPTH];
    logic [5:0]           e_op  [RS_DEPTH];
    logic [31:0]          e_v1  [RS_DEPTH];
    logic [31:0]          e_v2  [RS_DEPTH];
    logic [ROB_WIDTH-1:0] e_d1  [RS_DEPTH];
    logic [ROB_WIDTH-1:0] e_d2  [RS_DEPTH];
    logic [31:0]          e_pc  [RS_DEPTH];
    logic [31:0]          e_off [RS_DEPTH];
    logic [32:0]          wake1 [RS_DEPTH];
    logic [32:0]          wake2 [RS_DEPTH];
    logic [32:0]          iwake1, iwake2;
    logic [IDX_W-1:0]     disp_idx, free_idx;
    logic                 disp_any, do_issue;
    logic [31:0]          s_a, s_b, s_pc, s_off, alu_val, alu_jump;
    logic [5:0]           s_op;
    logic                 alu_br;
    logic [CNT_W-1:0]     free_cnt;

    // {hit, value}: lowest CDB port wins, registered self-broadcast is the fallback
    function automatic logic [32:0] snoop(input logic [ROB_WIDTH-1:0] tag);
        logic [32:0] r;
        r = '0;
        if (tag != '0) begin
            if (rs_ready && rs_rob_index == tag) r = {1'b1, rs_val};
            for (int k = CDB_PORTS - 1; k >= 0; k--)
                if (cdb_valid[k] && cdb_rob_index[k*ROB_WIDTH +: ROB_WIDTH] == tag)
                    r = {1'b1, cdb_val[k*32 +: 32]};
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            wake1[i] = snoop(e_d1[i]);
            wake2[i] = snoop(e_d2[i]);
        end
        iwake1 = snoop(issue_dep1);
        iwake2 = snoop(issue_dep2);
    end

    for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_elig
        assign elig[gi] = busy[gi] && (e_d1[gi] == '0) && (e_d2[gi] == '0);
    end

    always_comb begin
        pick = elig;
        for (int i = 0; i < RS_DEPTH; i++)
            for (int j = 0; j < RS_DEPTH; j++)
                if (elig[j] && older[j][i]) pick[i] = 1'b0;
        disp_any = |pick;
        disp_idx = '0;
        free_idx = '0;
        free_cnt = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (pick[i]) disp_idx = IDX_W'(i);
            if (!busy[i]) free_idx = IDX_W'(i);
            free_cnt = free_cnt + CNT_W'(!busy[i]);
        end
    end

    assign rs_free_cnt = free_cnt;
    assign rs_full     = (free_cnt == '0);
    assign do_issue    = issue_valid && !rs_full;

    always_comb begin
        busy_next = busy;
        if (disp_any) busy_next[disp_idx] = 1'b0;
        if (do_issue) busy_next[free_idx] = 1'b1;
        for (int j = 0; j < RS_DEPTH; j++) begin
            older_next[j] = older[j];
            if (do_issue) older_next[j][free_idx] = 1'b1;
        end
        if (do_issue) older_next[free_idx] = '0;
    end

    assign s_op  = e_op[disp_idx];
    assign s_a   = e_v1[disp_idx];
    assign s_b   = e_v2[disp_idx];
    assign s_pc  = e_pc[disp_idx];
    assign s_off = e_off[disp_idx];

    always_comb begin
        alu_val  = '0;
        alu_br   = 1'b0;
        alu_jump = '0;
        case (s_op)
            OP_LUI:   alu_val = s_a;
            OP_AUIPC: alu_val = s_pc + s_a;
            OP_JAL:   begin alu_val = s_pc + 32'd4; alu_br = 1'b1; alu_jump = s_pc + s_off; end
            OP_JALR:  begin alu_val = s_pc + 32'd4; alu_br = 1'b1; alu_jump = (s_a + s_off) & ~32'd1; end
            OP_BEQ:   begin alu_br = (s_a == s_b);                   alu_jump = s_pc + s_off; end
            OP_BNE:   begin alu_br = (s_a != s_b);                   alu_jump = s_pc + s_off; end
            OP_BLT:   begin alu_br = ($signed(s_a) < $signed(s_b));  alu_jump = s_pc + s_off; end
            OP_BGE:   begin alu_br = ($signed(s_a) >= $signed(s_b)); alu_jump = s_pc + s_off; end
            OP_BLTU:  begin alu_br = (s_a < s_b);                    alu_jump = s_pc + s_off; end
            OP_BGEU:  begin alu_br = (s_a >= s_b);                   alu_jump = s_pc + s_off; end
            OP_ADD, OP_ADDI:   alu_val = s_a + s_b;
            OP_SUB:            alu_val = s_a - s_b;
            OP_AND, OP_ANDI:   alu_val = s_a & s_b;
            OP_OR, OP_ORI:     alu_val = s_a | s_b;
            OP_XOR, OP_XORI:   alu_val = s_a ^ s_b;
            OP_SLT, OP_SLTI:   alu_val = {31'd0, $signed(s_a) < $signed(s_b)};
            OP_SLTU, OP_SLTIU: alu_val = {31'd0, s_a < s_b};
            OP_SLL, OP_SLLI:   alu_val = s_a << s_b[4:0];
            OP_SRL, OP_SRLI:   alu_val = s_a >> s_b[4:0];
            OP_SRA, OP_SRAI:   alu_val = $signed(s_a) >>> s_b[4:0];
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy         <= '0;
            for (int i = 0; i < RS_DEPTH; i++) older[i] <= '0;
            rs_ready     <= 1'b0;
            rs_rob_index <= '0;
            rs_val       <= '0;
            rs_actual_br <= 1'b0;
            rs_pc_jump   <= '0;
        end else if (clr_in) begin
            busy     <= '0;
            for (int i = 0; i < RS_DEPTH; i++) older[i] <= '0;
            rs_ready <= 1'b0;
        end else if (rdy_in) begin
            busy     <= busy_next;
            for (int i = 0; i < RS_DEPTH; i++) older[i] <= older_next[i];
            rs_ready <= disp_any;
            if (disp_any) begin
                rs_rob_index <= e_tag[disp_idx];
                rs_val       <= alu_val;
                rs_actual_br <= alu_br;
                rs_pc_jump   <= alu_jump;
            end
        end
    end

    // Payload needs no reset: it is only ever read through an occupied entry.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !clr_in) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (do_issue && free_idx == IDX_W'(i)) begin
                    e_tag[i] <= issue_rob_index;
                    e_op[i]  <= issue_op_id;
                    e_pc[i]  <= issue_pc;
                    e_off[i] <= issue_offset;
                    e_v1[i]  <= iwake1[32] ? iwake1[31:0] : issue_val1;
                    e_d1[i]  <= iwake1[32] ? '0 : issue_dep1;
                    e_v2[i]  <= iwake2[32] ? iwake2[31:0] : issue_val2;
                    e_d2[i]  <= iwake2[32] ? '0 : issue_dep2;
                end else if (busy[i]) begin
                    if (wake1[i][32]) begin
                        e_v1[i] <= wake1[i][31:0];
                        e_d1[i] <= '0;
                    end
                    if (wake2[i][32]) begin
                        e_v2[i] <= wake2[i][31:0];
                        e_d2[i] <= '0;
                    end
                end
            end
        end
    end
endmodule
